// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the fetch PC, reads INST_MEM and buffers
// fetched words in a small prefetch FIFO presented to decode via valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [31:0]   fpc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic full;
  logic deq;
  logic enq;

  // Handshake decode: a full FIFO may still accept a word when the head leaves.
  always_comb begin
    full = 1'b0;
    deq  = 1'b0;
    enq  = 1'b0;
    full = (count == DEPTH_CNT);
    deq  = id_valid && id_ready;
    enq  = !redirect_valid && (!full || deq);
  end

  // Fetch PC, FIFO storage, pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc    <= RESET_PC & ~32'h0000_0003;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= 32'h0000_0000;
        inst_mem[i] <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      fpc    <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        pc_mem[wr_ptr]   <= fpc;
        inst_mem[wr_ptr] <= im_inst;
        wr_ptr           <= wr_ptr + PTR_ONE;
        fpc              <= fpc + 32'd4;
      end else begin
        wr_ptr <= wr_ptr;
        fpc    <= fpc;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign im_addr  = {2'b00, fpc[31:2]};
  assign id_valid = (count != '0);
  assign id_inst  = inst_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic,
// checked against a queue-based model of the prefetch buffer.
module tb_inst_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [31:0] mfpc;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_inst(im_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  // Memory word k holds A000_0000 + k.
  assign im_inst = 32'hA000_0000 + im_addr;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
    chk("im_addr", im_addr, mfpc >> 2);
    chk("count", 32'(dut.count), 32'(q.size()));
    if (q.size() != 0) begin
      chk("id_pc", id_pc, q[0]);
      chk("id_inst", id_inst, word_at(q[0]));
    end
  endtask

  task automatic model(input logic rdy, input logic rv, input logic [31:0] rpc);
    if (rv) begin
      q.delete();
      mfpc = {rpc[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back(mfpc);
        mfpc = mfpc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model(rdy, rv, rpc);
    @(posedge clk);
    #1;
    check_all();
    redirect_valid = 1'b0;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases after one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    mfpc = 32'h0000_0000;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_im_addr", im_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    do_reset();

    // Reset and stream
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

    // Backpressure and full, then drain
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("bp_head", id_inst, 32'hA000_0000);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

    // Full plus single dequeue
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // Redirect with three entries buffered
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0103);
    cycle(1'b1, 1'b0, 32'h0);
    chk("redir_pc", id_pc, 32'h0000_0100);
    chk("redir_inst", id_inst, 32'hA000_0040);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // Fetch PC wrap-around
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), $urandom);
    end

    // Reset mid-operation with two entries streaming
    cycle(1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
